// File: rtl/iro_sample_ctrl.sv
// Sequencer and capture buffer for an instrumented ring oscillator. It loads the seed serially,
// runs enable/hold shots and stores the synchronised frozen phase vector of each shot in a FIFO.
module iro_sample_ctrl #(
  parameter int unsigned N_STAGES = 25,
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned RUN_W    = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bdat,
  input  logic                bvalid,
  input  logic                start,
  input  logic [RUN_W-1:0]    run_len,
  input  logic [7:0]          shots,
  input  logic [SEL_W-1:0]    n_stages_cfg,
  input  logic [PHASE_W-1:0]  ro_phases,
  output logic [N_STAGES-1:0] ro_seed,
  output logic                ro_enable,
  output logic                ro_hold,
  output logic [SEL_W-1:0]    ro_n_stages,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  output logic [PHASE_W-1:0]  rd_data,
  output logic                empty,
  output logic                full,
  output logic                overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {StIdle, StRun, StHold, StSettle, StCapture, StGap} state_e;

  state_e              state_q, state_d;
  logic [N_STAGES-1:0] seed_q;
  logic [SEL_W-1:0]    sel_q;
  logic [RUN_W-1:0]    run_len_q;
  logic [RUN_W-1:0]    cnt_q;
  logic [7:0]          shots_q;
  logic [PHASE_W-1:0]  sync1_q;
  logic [PHASE_W-1:0]  sync_ph;
  logic [PHASE_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                overflow_q;
  logic                push, pop, push_ok, last_shot;

  assign last_shot = (shots_q == 8'd1);

  always_comb begin
    state_d   = state_q;
    ro_enable = 1'b0;
    ro_hold   = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        ro_enable = 1'b1;
        if (cnt_q == run_len_q) state_d = StHold;
      end
      StHold: begin
        ro_enable = 1'b1;
        ro_hold   = 1'b1;
        if (cnt_q == RUN_W'(2)) state_d = StSettle;
      end
      StSettle: begin
        ro_enable = 1'b1;
        ro_hold   = 1'b1;
        if (cnt_q == RUN_W'(3)) state_d = StCapture;
      end
      StCapture: begin
        push = 1'b1;
        if (last_shot) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          // Keep the RO frozen through capture so the only enable-low cycle is the gap.
          ro_enable = 1'b1;
          ro_hold   = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      seed_q    <= '0;
      sel_q     <= '0;
      run_len_q <= '0;
      cnt_q     <= '0;
      shots_q   <= '0;
      sync1_q   <= '0;
      sync_ph   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= ro_phases;
      sync_ph <= sync1_q;
      // Cycle counter restarts at 1 on every state change.
      if (state_d != state_q) begin
        cnt_q <= RUN_W'(1);
      end else if (state_q != StIdle) begin
        cnt_q <= cnt_q + RUN_W'(1);
      end
      if (state_q == StIdle) begin
        if (bvalid) seed_q <= {seed_q[N_STAGES-2:0], bdat};
        if (start) begin
          sel_q     <= n_stages_cfg;
          run_len_q <= (run_len == '0) ? RUN_W'(1) : run_len;
          shots_q   <= (shots == 8'd0) ? 8'd1 : shots;
        end
      end
      if (state_q == StCapture) shots_q <= shots_q - 8'd1;
    end
  end

  assign ro_seed     = seed_q;
  assign ro_n_stages = sel_q;
  assign busy        = (state_q != StIdle);

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = rd_en && !empty;
  assign push_ok  = push && (!full || pop);
  assign rd_data  = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sync_ph;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

endmodule
